// File: rtl/l1_refill_ctrl.sv
// L1 miss-refill controller: queues miss addresses, merges duplicates, fetches each
// word from backing memory and returns it to the L1 as a one-cycle fill pulse.
module l1_refill_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int QDEPTH  = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_valid,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              miss_ready,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    input  logic              mem_resp_err,
    output logic              fill_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_err,
    output logic              busy
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_FILL = 2'd3;

    logic [ADDR_W-1:0] fifo_mem [QDEPTH];
    logic [PW-1:0]     head_reg, tail_reg;
    logic [CW-1:0]     count_reg, count_next;
    logic [1:0]        state_reg, state_next;
    logic [TW-1:0]     timer_reg;
    logic [ADDR_W-1:0] inflight_reg;

    logic              mem_req_valid_reg, fill_valid_reg, fill_err_reg, busy_reg;
    logic [ADDR_W-1:0] mem_req_addr_reg, fill_addr_reg;
    logic [DATA_W-1:0] fill_data_reg;

    logic [QDEPTH-1:0] entry_hit;
    logic              inflight_hit, dup, push, pop, fill_start;

    // An entry is live when its distance from head is below the occupancy count.
    generate
        for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_hit
            logic [PW-1:0] offset;
            assign offset        = PW'(gi) - head_reg;
            assign entry_hit[gi] = ({1'b0, offset} < count_reg) && (fifo_mem[gi] == miss_addr);
        end
    endgenerate

    assign miss_ready   = count_reg < CW'(QDEPTH);
    assign inflight_hit = ((state_reg == S_WAIT) || (state_reg == S_FILL)) && (inflight_reg == miss_addr);
    assign dup          = (|entry_hit) || inflight_hit;
    assign push         = miss_valid && miss_ready && !dup;
    assign pop          = (state_reg == S_REQ) && mem_req_ready;
    assign fill_start   = (state_reg == S_WAIT) && (state_next == S_FILL);

    always_comb begin
        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + CW'(1);
        else if (pop && !push)
            count_next = count_reg - CW'(1);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (count_reg != '0) state_next = S_REQ;
            S_REQ:  if (mem_req_ready) state_next = S_WAIT;
            S_WAIT: if (mem_resp_valid || (timer_reg == TW'(TIMEOUT - 1))) state_next = S_FILL;
            default: state_next = S_IDLE;
        endcase
    end

    // Storage has no reset; flushing is done by clearing the pointers and count.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[tail_reg] <= miss_addr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg          <= '0;
            tail_reg          <= '0;
            count_reg         <= '0;
            state_reg         <= S_IDLE;
            timer_reg         <= '0;
            inflight_reg      <= '0;
            mem_req_valid_reg <= 1'b0;
            mem_req_addr_reg  <= '0;
            fill_valid_reg    <= 1'b0;
            fill_addr_reg     <= '0;
            fill_data_reg     <= '0;
            fill_err_reg      <= 1'b0;
            busy_reg          <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (push)
                tail_reg <= tail_reg + PW'(1);
            if (pop) begin
                head_reg     <= head_reg + PW'(1);
                inflight_reg <= fifo_mem[head_reg];
                timer_reg    <= '0;
            end else if (state_reg == S_WAIT) begin
                timer_reg <= timer_reg + TW'(1);
            end

            // Request outputs are loaded on entry to REQ so they appear with the state.
            mem_req_valid_reg <= (state_next == S_REQ);
            if (state_next == S_REQ)
                mem_req_addr_reg <= fifo_mem[head_reg];

            fill_valid_reg <= fill_start;
            if (fill_start) begin
                fill_addr_reg <= inflight_reg;
                if (mem_resp_valid) begin
                    fill_err_reg  <= mem_resp_err;
                    fill_data_reg <= mem_resp_err ? '0 : mem_resp_data;
                end else begin
                    fill_err_reg  <= 1'b1;
                    fill_data_reg <= '0;
                end
            end

            busy_reg <= (count_next != '0) || (state_next != S_IDLE);
        end
    end

    assign mem_req_valid = mem_req_valid_reg;
    assign mem_req_addr  = mem_req_addr_reg;
    assign fill_valid    = fill_valid_reg;
    assign fill_addr     = fill_addr_reg;
    assign fill_data     = fill_data_reg;
    assign fill_err      = fill_err_reg;
    assign busy          = busy_reg;

endmodule
